// File: rtl/risc_toy_pkg.sv
// Shared types and constants for the RISC_TOY fetch stage.
package risc_toy_pkg;

    localparam int IADDR_W = 30;
    localparam int INSTR_W = 32;

    localparam logic [IADDR_W-1:0] RESET_PC_DEF = '0;

    // One queued fetch: the instruction word and the word address it came from.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [IADDR_W-1:0] iaddr;
    } fetch_entry_t;

endpackage

// File: rtl/risc_toy_fetch_if.sv
// Fetch-stage bus: instruction-memory request/return, redirect from execute,
// and the valid/stall handshake towards decode.
interface risc_toy_fetch_if;
    import risc_toy_pkg::*;

    logic               IREQ;
    logic [IADDR_W-1:0] IADDR;
    logic [INSTR_W-1:0] INSTR;
    logic               REDIR;
    logic [IADDR_W-1:0] REDIR_ADDR;
    logic               STALL;
    logic               FD_VALID;
    logic [INSTR_W-1:0] FD_INSTR;
    logic [IADDR_W-1:0] FD_IADDR;
    logic [IADDR_W-1:0] FD_LINK;

    // Fetch stage side.
    modport master (
        output IREQ, IADDR, FD_VALID, FD_INSTR, FD_IADDR, FD_LINK,
        input  INSTR, REDIR, REDIR_ADDR, STALL
    );

    // Memory / execute / decode side.
    modport slave (
        input  IREQ, IADDR, FD_VALID, FD_INSTR, FD_IADDR, FD_LINK,
        output INSTR, REDIR, REDIR_ADDR, STALL
    );

endinterface

// File: rtl/risc_toy_iq.sv
// Small circular instruction queue. Flush empties it in one cycle and
// takes priority over push/pop. Entries reset to zero so the head reads
// as zero straight out of reset.
module risc_toy_iq
    import risc_toy_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output fetch_entry_t  head_data
);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    // Pointer, count and storage update; pointers wrap naturally (DEPTH is 2^PW).
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            head  <= tail;
            count <= '0;
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= tail + PW'(1);
            end
            if (pop) head <= head + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head_data = mem[head];

endmodule

// File: rtl/risc_toy_fetch.sv
// RISC_TOY instruction fetch: owns the fetch PC, issues one request per
// cycle while the queue has room for everything in flight, and restarts
// on a redirect from execute.
module risc_toy_fetch
    import risc_toy_pkg::*;
#(
    parameter logic [IADDR_W-1:0] RESET_PC = RESET_PC_DEF,
    parameter int                 DEPTH    = 2
) (
    input logic              CLK,
    input logic              RST,
    risc_toy_fetch_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = CW + 1;

    logic [IADDR_W-1:0] pc;
    logic [IADDR_W-1:0] pend_addr;
    logic               pend;
    logic [CW-1:0]      count;
    fetch_entry_t       head_q;
    fetch_entry_t       push_d;
    logic               fd_valid;
    logic               deq;
    logic               issue;
    logic [OW-1:0]      occ;

    assign fd_valid = (count != '0);
    assign deq      = fd_valid & ~bus.STALL & ~bus.REDIR;

    // Slots committed after this cycle; a request only goes out if its
    // return is guaranteed a free entry, so the queue cannot overflow.
    assign occ   = OW'(count) + OW'(pend) - OW'(deq);
    assign issue = (occ < OW'(DEPTH));

    assign bus.IREQ  = ~RST & (bus.REDIR | issue);
    assign bus.IADDR = bus.REDIR ? bus.REDIR_ADDR : pc;

    assign push_d.instr = bus.INSTR;
    assign push_d.iaddr = pend_addr;

    risc_toy_iq #(.DEPTH(DEPTH)) u_iq (
        .CLK       (CLK),
        .RST       (RST),
        .push      (pend & ~bus.REDIR),
        .push_data (push_d),
        .pop       (deq),
        .flush     (bus.REDIR),
        .count     (count),
        .head_data (head_q)
    );

    // PC and in-flight tracking; a redirect restarts fetch at the target.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc        <= RESET_PC;
            pend      <= 1'b0;
            pend_addr <= '0;
        end else if (bus.REDIR) begin
            pc        <= bus.REDIR_ADDR + IADDR_W'(1);
            pend      <= 1'b1;
            pend_addr <= bus.REDIR_ADDR;
        end else begin
            pend      <= issue;
            pend_addr <= pc;
            if (issue) pc <= pc + IADDR_W'(1);
        end
    end

    assign bus.FD_VALID = fd_valid;
    assign bus.FD_INSTR = head_q.instr;
    assign bus.FD_IADDR = head_q.iaddr;
    assign bus.FD_LINK  = head_q.iaddr + IADDR_W'(1);

endmodule

// File: tb/tb_risc_toy_fetch.sv
// Directed bench for risc_toy_fetch: the stimulus queues the addresses it
// expects decode to accept, and a monitor compares every accepted
// instruction against that queue.
module tb_risc_toy_fetch;
    import risc_toy_pkg::*;

    logic CLK = 1'b0;
    logic RST;

    risc_toy_fetch_if bus();

    risc_toy_fetch #(.RESET_PC(30'h0), .DEPTH(2)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    logic [IADDR_W-1:0] exp_q[$];

    // Memory: returns 0x1800_0000+addr one cycle after a request, else holds.
    always @(posedge CLK)
        if (bus.IREQ) bus.INSTR <= 32'h1800_0000 + {2'b00, bus.IADDR};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic exp_range(input logic [IADDR_W-1:0] start, input int n);
        logic [IADDR_W-1:0] a;
        a = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(a);
            a = a + 30'd1;
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every instruction decode accepts must be the next expected one.
    always @(negedge CLK) begin
        logic [IADDR_W-1:0] e;
        logic [IADDR_W-1:0] l;
        if (!RST && bus.FD_VALID && !bus.STALL && !bus.REDIR) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL fd_extra: got iaddr %0h, want no delivery", bus.FD_IADDR);
            end else begin
                e = exp_q.pop_front();
                l = e + 30'd1;
                chk("fd_iaddr", 64'(bus.FD_IADDR), 64'(e));
                chk("fd_instr", 64'(bus.FD_INSTR), 64'(32'h1800_0000 + {2'b00, e}));
                chk("fd_link",  64'(bus.FD_LINK),  64'(l));
            end
        end
    end

    initial begin
        RST = 1'b1;
        bus.STALL = 1'b0;
        bus.REDIR = 1'b0;
        bus.REDIR_ADDR = '0;
        repeat (2) step();
        #1;
        chk("rst_ireq",     64'(bus.IREQ),     64'd0);
        chk("rst_iaddr",    64'(bus.IADDR),    64'd0);
        chk("rst_fd_valid", 64'(bus.FD_VALID), 64'd0);
        chk("rst_fd_instr", 64'(bus.FD_INSTR), 64'd0);
        chk("rst_fd_iaddr", 64'(bus.FD_IADDR), 64'd0);
        chk("rst_fd_link",  64'(bus.FD_LINK),  64'd1);

        // c0: release reset, stream from address 0
        step(); RST = 1'b0;
        exp_range(30'h0, 8);
        #1;
        chk("c0_ireq",  64'(bus.IREQ),  64'd1);
        chk("c0_iaddr", 64'(bus.IADDR), 64'd0);
        step(); #1;                                        // c1
        chk("c1_fd_valid", 64'(bus.FD_VALID), 64'd0);
        chk("c1_iaddr",    64'(bus.IADDR),    64'd1);
        step(); #1;                                        // c2
        chk("c2_fd_valid", 64'(bus.FD_VALID), 64'd1);
        chk("c2_fd_iaddr", 64'(bus.FD_IADDR), 64'd0);
        repeat (5) step();                                 // c7: head = 5
        bus.STALL = 1'b1;
        #1;
        chk("stall_fd_iaddr0", 64'(bus.FD_IADDR), 64'd5);
        chk("stall_ireq0",     64'(bus.IREQ),     64'd0);
        step(); #1;                                        // c8
        chk("stall_fd_iaddr1", 64'(bus.FD_IADDR), 64'd5);
        chk("stall_ireq1",     64'(bus.IREQ),     64'd0);
        repeat (2) step();                                 // c10
        step(); bus.STALL = 1'b0;                          // c11
        #1;
        chk("unstall_ireq",  64'(bus.IREQ),  64'd1);
        chk("unstall_iaddr", 64'(bus.IADDR), 64'd7);
        repeat (3) step();                                 // c14: head 8, pend=1 count=1
        bus.REDIR = 1'b1;
        bus.REDIR_ADDR = 30'h100;
        #1;
        chk("redir_ireq",  64'(bus.IREQ),  64'd1);
        chk("redir_iaddr", 64'(bus.IADDR), 64'h100);
        exp_range(30'h100, 2);
        step(); bus.REDIR = 1'b0;                          // c15
        #1;
        chk("redir_gap_valid", 64'(bus.FD_VALID), 64'd0);
        chk("redir_next_addr", 64'(bus.IADDR),    64'h101);
        step(); #1;                                        // c16
        chk("redir_target", 64'(bus.FD_IADDR), 64'h100);
        repeat (2) step();                                 // c18: REDIR with STALL
        bus.REDIR = 1'b1;
        bus.STALL = 1'b1;
        bus.REDIR_ADDR = 30'h3FFF_FFFE;
        #1;
        chk("rs_iaddr", 64'(bus.IADDR), 64'h3FFF_FFFE);
        exp_range(30'h3FFF_FFFE, 3);
        step(); bus.REDIR = 1'b0; bus.STALL = 1'b0;        // c19
        #1;
        chk("rs_gap_valid", 64'(bus.FD_VALID), 64'd0);
        step(); #1;                                        // c20
        chk("wrap_iaddr",   64'(bus.IADDR),    64'd0);
        chk("rs_target",    64'(bus.FD_IADDR), 64'h3FFF_FFFE);
        step(); #1;                                        // c21
        chk("wrap_fd_iaddr", 64'(bus.FD_IADDR), 64'h3FFF_FFFF);
        chk("wrap_fd_link",  64'(bus.FD_LINK),  64'd0);
        repeat (2) step();                                 // c23: stall to fill queue
        bus.STALL = 1'b1;
        step(); #1;                                        // c24: queue full
        chk("full_valid", 64'(bus.FD_VALID), 64'd1);
        chk("full_ireq",  64'(bus.IREQ),     64'd0);
        RST = 1'b1;
        bus.STALL = 1'b0;
        #1;
        chk("midrst_valid", 64'(bus.FD_VALID), 64'd0);
        chk("midrst_ireq",  64'(bus.IREQ),     64'd0);
        step(); step(); RST = 1'b0;                        // c26: release
        exp_range(30'h0, 4);
        #1;
        chk("rerst_ireq",  64'(bus.IREQ),  64'd1);
        chk("rerst_iaddr", 64'(bus.IADDR), 64'd0);
        step(); #1;                                        // c27: stale INSTR dropped
        chk("rerst_stale_valid", 64'(bus.FD_VALID), 64'd0);
        repeat (5) step();                                 // c32: stop consuming
        bus.STALL = 1'b1;
        repeat (3) step();
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/risc_toy_fetch.md
# risc_toy_fetch

Instruction-fetch stage for the RISC_TOY pipeline. It sits between instruction memory and the decode stage:
- owns the fetch PC and drives the IREQ/IADDR request to instruction memory;
- captures INSTR one cycle later into a small instruction queue;
- presents one instruction per cycle to decode with a valid/stall handshake;
- accepts redirects (taken branch or jump) from execute, flushing everything in flight.

## Interface
Parameters:
- RESET_PC, default 30'h0: word address fetched first after reset.
- DEPTH, default 2: instruction-queue entries. Power of two, ≥ 2.

Ports:
- CLK  in  1  single clock, all state on rising edge.
- RST  in  1  reset, asynchronous, active-high. Clears all state immediately.
- IREQ  out  1  instruction-memory request this cycle.
- IADDR  out  30  word address of the request. Valid whenever IREQ=1.
- INSTR  in  32  instruction data, valid exactly one cycle after a cycle with IREQ=1. Memory always accepts requests.
- REDIR  in  1  redirect from execute. Flush and restart at REDIR_ADDR.
- REDIR_ADDR  in  30  redirect target, word address.
- STALL  in  1  decode cannot accept this cycle.
- FD_VALID  out  1  queue head holds a valid instruction.
- FD_INSTR  out  32  head instruction.
- FD_IADDR  out  30  word address of the head instruction.
- FD_LINK  out  30  FD_IADDR+1, mod 2^30. This is the link value for BRL/JL.

## Operation
State:
- pc (next sequential address);
- pend (one request in flight), pend_addr;
- queue of {instr, iaddr} entries with head, tail and count.

Dequeue:
- deq = FD_VALID & ~STALL & ~REDIR.

Issue rule (combinational), when REDIR=0:
- IREQ = (count + pend − deq) < DEPTH.
- IADDR = pc.

Redirect cycle (REDIR=1), which overrides everything else:
- IREQ = 1, IADDR = REDIR_ADDR.
- Queue is emptied: count ← 0, head = tail.
- INSTR arriving this cycle is discarded, not enqueued.
- pc ← REDIR_ADDR+1, pend ← 1, pend_addr ← REDIR_ADDR.

Normal cycle:
- If pend=1, enqueue {INSTR, pend_addr} at tail.
- pend ← IREQ, pend_addr ← pc.
- If IREQ=1, pc ← pc+1.
- Enqueue and dequeue may occur in the same cycle; count then stays unchanged.

Boundary conditions:
- The issue rule guarantees a returning instruction always finds a free slot, so the queue never overflows.
- pc and FD_LINK wrap from 30'h3FFFFFFF to 0.
- REDIR together with STALL: REDIR wins, and the head is dropped without being consumed.
- RST asserted mid-operation: all state clears asynchronously. Any INSTR returning after release is ignored, because pend=0.

## Timing
Reset values:
- IREQ=0 while RST=1; IADDR=RESET_PC.
- FD_VALID=0, FD_INSTR=0, FD_IADDR=0, FD_LINK=1.
- pc=RESET_PC, pend=0, count=0.

Cycle-level behaviour:
- First cycle after RST deasserts: IREQ=1, IADDR=RESET_PC.
- Latency from request to decode: issue in cycle t, INSTR in cycle t+1, FD_VALID in cycle t+2.
- Throughput: one instruction per cycle with STALL=0 and DEPTH=2. Steady state is count=1, pend=1.
- Stall: no instruction is lost or duplicated. IREQ drops in the first stall cycle in which count+pend reaches DEPTH. It reasserts in the first cycle STALL=0.
- Redirect penalty: REDIR in cycle t puts the target on IADDR in cycle t and gives FD_VALID=1 for the target in cycle t+2. FD_VALID=0 in cycle t+1.

## Structure
- Shared package risc_toy_pkg:
  - IADDR_W=30 and INSTR_W=32 constants;
  - queue entry struct fetch_entry_t {instr, iaddr};
  - RESET_PC default constant.
- Sub-module risc_toy_iq: circular FIFO of fetch_entry_t.
  - Ports: push, pop, flush, count, head data.
  - Pointers wrap modulo DEPTH.
- Top level holds pc, pend, the issue rule and redirect logic.

## Test plan
- Reset release, STALL=0, memory returns INSTR=32'h1800_0000+addr → IADDR 0,1,2,… from the first cycle. FD_VALID rises 2 cycles later, FD_IADDR 0,1,2,… back-to-back, FD_LINK=FD_IADDR+1.
- STALL held for 4 cycles while FD_IADDR=5 → FD_IADDR stays 5. IREQ low after occupancy hits 2. On release, FD_IADDR 6,7,… with no gap or duplicate.
- REDIR=1 with REDIR_ADDR=30'h100 while pend=1 and count=1 → IADDR=30'h100 that cycle, FD_VALID=0 next cycle, then FD_IADDR=30'h100, 30'h101. Stale INSTR never appears.
- REDIR and STALL in the same cycle → redirect taken, old head dropped, target delivered 2 cycles later.
- pc at 30'h3FFFFFFF → next IADDR=0, FD_LINK for 30'h3FFFFFFF equals 0.
- RST pulsed mid-stream with the queue full → FD_VALID=0 and IREQ=0 immediately. After release, refetch starts at RESET_PC, and the INSTR returning in the first post-reset cycle is not enqueued.
